mau_controller: RTL and testbench

MAU_CONTROLLER -- requirements
Module: mau_controller

---
 rtl/mau_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_mau_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mau_controller.sv
// Sequencer for the matrix arithmetic unit: decodes host instructions into BRAM strobes, mux selects and addresses.
// Optional abort of LOAD/STORE with instruction byte 8'hFF is enabled by defining MAU_CTRL_ABORT_EN.
module mau_controller #(
  parameter int matrix_dim = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] host_instruction,
  input  logic       instr_valid,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       busy_flag,
  output logic [7:0] host_input,
  output logic [8:0] offset,
  output logic [3:0] line_read_from_host,
  output logic [3:0] chunk_read_from_bram,
  output logic [1:0] aa_mux_sel,
  output logic [1:0] dd_mux_sel,
  output logic [1:0] arithmetic_mux_sel,
  output logic       bram_in_mux_sel,
  output logic       data_out_valid
);

  localparam int N = matrix_dim * matrix_dim;
  localparam logic [8:0] LAST = 9'(N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH2 = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    DRAIN  = 3'd4,
    EXEC   = 3'd5,
    WRITE  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] count_q, count_d;
  logic [5:0] instr_q, instr_d;
  logic [1:0] dest_q, dest_d;
  logic       busy_q, busy_d;
  logic [7:0] host_input_q, host_input_d;
  logic [8:0] offset_q, offset_d;
  logic [3:0] line_q, line_d;
  logic [3:0] chunk_q, chunk_d;
  logic [1:0] aa_q, aa_d;
  logic [1:0] dd_q, dd_d;
  logic [1:0] arith_q, arith_d;
  logic       bram_in_q, bram_in_d;
  logic       dov_q, dov_d;
  logic       abort_s;
  logic       load_done_s;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0010;
      2'd2:    r = 4'b0100;
      2'd3:    r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

`ifdef MAU_CTRL_ABORT_EN
  assign abort_s = instr_valid && (host_instruction == 8'hFF);
`else
  assign abort_s = 1'b0;
`endif

  // The last LOAD strobe is on the outputs: leave LOAD on the following edge.
  assign load_done_s = (line_q != 4'b0000) && (offset_q == LAST);

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    instr_d      = instr_q;
    dest_d       = dest_q;
    host_input_d = host_input_q;
    offset_d     = offset_q;
    line_d       = 4'b0000;
    chunk_d      = 4'b0000;
    aa_d         = aa_q;
    dd_d         = dd_q;
    arith_d      = arith_q;
    bram_in_d    = bram_in_q;
    dov_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = host_instruction[5:0];
          count_d = 9'd0;
          case (host_instruction[7:6])
            2'b00: begin
              state_d = LOAD;
              dest_d  = host_instruction[1:0];
            end
            2'b01: begin
              state_d  = STORE;
              dd_d     = host_instruction[1:0];
              offset_d = 9'd0;
            end
            2'b10: begin
              state_d = FETCH2;
            end
            2'b11: begin
              state_d   = EXEC;
              aa_d      = host_instruction[3:2];
              dest_d    = host_instruction[1:0];
              bram_in_d = 1'b1;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      FETCH2: begin
        if (instr_valid) begin
          state_d   = EXEC;
          dest_d    = host_instruction[1:0];
          arith_d   = instr_q[5:4];
          aa_d      = instr_q[3:2];
          dd_d      = instr_q[1:0];
          bram_in_d = 1'b0;
        end else begin
          state_d = FETCH2;
        end
      end

      LOAD: begin
        if (abort_s || load_done_s) begin
          state_d = IDLE;
          count_d = 9'd0;
        end else if (data_valid) begin
          line_d       = onehot4(dest_q);
          host_input_d = data_in;
          offset_d     = count_q;
          if (count_q == LAST) begin
            count_d = 9'd0;
          end else begin
            count_d = count_q + 9'd1;
          end
        end else begin
          state_d = LOAD;
        end
      end

      STORE: begin
        if (abort_s) begin
          state_d = IDLE;
          count_d = 9'd0;
        end else begin
          dov_d = 1'b1;
          if (count_q == LAST) begin
            state_d = DRAIN;
            count_d = 9'd0;
          end else begin
            count_d  = count_q + 9'd1;
            offset_d = count_q + 9'd1;
          end
        end
      end

      DRAIN: begin
        state_d = IDLE;
      end

      EXEC: begin
        state_d = WRITE;
        chunk_d = onehot4(dest_q);
      end

      WRITE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        count_d = 9'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= 9'd0;
      instr_q      <= 6'd0;
      dest_q       <= 2'd0;
      busy_q       <= 1'b0;
      host_input_q <= 8'd0;
      offset_q     <= 9'd0;
      line_q       <= 4'b0000;
      chunk_q      <= 4'b0000;
      aa_q         <= 2'd0;
      dd_q         <= 2'd0;
      arith_q      <= 2'd0;
      bram_in_q    <= 1'b0;
      dov_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      instr_q      <= instr_d;
      dest_q       <= dest_d;
      busy_q       <= busy_d;
      host_input_q <= host_input_d;
      offset_q     <= offset_d;
      line_q       <= line_d;
      chunk_q      <= chunk_d;
      aa_q         <= aa_d;
      dd_q         <= dd_d;
      arith_q      <= arith_d;
      bram_in_q    <= bram_in_d;
      dov_q        <= dov_d;
    end
  end

  assign busy_flag            = busy_q;
  assign host_input           = host_input_q;
  assign offset               = offset_q;
  assign line_read_from_host  = line_q;
  assign chunk_read_from_bram = chunk_q;
  assign aa_mux_sel           = aa_q;
  assign dd_mux_sel           = dd_q;
  assign arithmetic_mux_sel   = arith_q;
  assign bram_in_mux_sel      = bram_in_q;
  assign data_out_valid       = dov_q;

endmodule

// File: tb/tb_mau_controller.sv
// Scoreboard bench for mau_controller: directed instructions push expected strobe/valid events, a monitor pops and compares.
module tb_mau_controller;

  logic       clk;
  logic       rst;
  logic [7:0] host_instruction;
  logic       instr_valid;
  logic [7:0] data_in;
  logic       data_valid;
  logic       busy_flag;
  logic [7:0] host_input;
  logic [8:0] offset;
  logic [3:0] line_read_from_host;
  logic [3:0] chunk_read_from_bram;
  logic [1:0] aa_mux_sel;
  logic [1:0] dd_mux_sel;
  logic [1:0] arithmetic_mux_sel;
  logic       bram_in_mux_sel;
  logic       data_out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_load[$];
  logic [31:0] q_store[$];
  logic [31:0] q_chunk[$];
  logic [8:0]  prev_offset;
  logic [31:0] mon_exp;

  mau_controller #(.matrix_dim(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .host_instruction     (host_instruction),
    .instr_valid          (instr_valid),
    .data_in              (data_in),
    .data_valid           (data_valid),
    .busy_flag            (busy_flag),
    .host_input           (host_input),
    .offset               (offset),
    .line_read_from_host  (line_read_from_host),
    .chunk_read_from_bram (chunk_read_from_bram),
    .aa_mux_sel           (aa_mux_sel),
    .dd_mux_sel           (dd_mux_sel),
    .arithmetic_mux_sel   (arithmetic_mux_sel),
    .bram_in_mux_sel      (bram_in_mux_sel),
    .data_out_valid       (data_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with empty scoreboard queue", name);
  endtask

  // Monitor: compare each output event against the head of its queue.
  always @(negedge clk) begin
    if (line_read_from_host != 4'b0000) begin
      if (q_load.size() == 0) unexpected("load_strobe");
      else begin
        mon_exp = q_load.pop_front();
        chk("load_strobe", {43'd0, line_read_from_host, offset, host_input}, {32'd0, mon_exp});
      end
    end
    if (data_out_valid) begin
      if (q_store.size() == 0) unexpected("store_valid");
      else begin
        mon_exp = q_store.pop_front();
        chk("store_valid", {53'd0, dd_mux_sel, prev_offset}, {32'd0, mon_exp});
      end
    end
    if (chunk_read_from_bram != 4'b0000) begin
      if (q_chunk.size() == 0) unexpected("chunk_strobe");
      else begin
        mon_exp = q_chunk.pop_front();
        chk("chunk_strobe", {53'd0, chunk_read_from_bram, aa_mux_sel, dd_mux_sel,
                             arithmetic_mux_sel, bram_in_mux_sel}, {32'd0, mon_exp});
      end
    end
    prev_offset = offset;
  end

  task automatic issue(input logic [7:0] b);
    @(negedge clk);
    host_instruction = b;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    host_instruction = 8'h00;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_flag && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Issue a STORE, optionally injecting one instruction byte at busy cycle inj_at.
  task automatic store_run(input logic [7:0] b, input int inj_at, input logic [7:0] inj_byte, output int n);
    issue(b);
    chk("store_first_offset", {55'd0, offset}, 64'd0);
    n = 0;
    while (busy_flag && n < 2000) begin
      n++;
      if (n == inj_at) begin
        host_instruction = inj_byte;
        instr_valid = 1'b1;
      end else begin
        host_instruction = 8'h00;
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    host_instruction = 8'h00;
  endtask

  function automatic logic [63:0] all_outputs();
    return {30'd0, busy_flag, host_input, offset, line_read_from_host, chunk_read_from_bram,
            aa_mux_sel, dd_mux_sel, arithmetic_mux_sel, bram_in_mux_sel, data_out_valid};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int abort_valids;
    int abort_busy;
    rst = 1'b1;
    host_instruction = 8'h00;
    instr_valid = 1'b0;
    data_in = 8'h00;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;

    // LOAD 8'h02: 64 bytes with gaps, strobe 4'b0100.
    host_instruction = 8'h02;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    host_instruction = 8'h00;
    chk("load_busy_rise", {63'd0, busy_flag}, 64'd1);
    for (int i = 0; i < 64; i++) begin
      if ((i % 7) == 3 || (i % 11) == 0) begin
        data_valid = 1'b0;
        @(negedge clk);
      end
      data_valid = 1'b1;
      data_in = 8'(i);
      q_load.push_back({11'd0, 4'b0100, 9'(i), 8'(i)});
      @(negedge clk);
    end
    data_valid = 1'b0;
    wait_idle(n);
    chk("load_tail_cycles", 64'(n), 64'd1);

    // data_valid in IDLE must not strobe.
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data_in = 8'hA5;
      @(negedge clk);
      chk("idle_no_strobe", {60'd0, line_read_from_host}, 64'd0);
    end
    data_valid = 1'b0;

    // STORE 8'h41 with an ignored instruction byte mid-way.
    for (int i = 0; i < 64; i++) q_store.push_back({21'd0, 2'd1, 9'(i)});
    store_run(8'h41, 5, 8'h00, n);
    chk("store41_busy_cycles", 64'(n), 64'd65);

    // ARITH 8'hA1 then 8'h03.
    q_chunk.push_back({21'd0, 4'b1000, 2'd0, 2'd1, 2'd2, 1'b0});
    @(negedge clk);
    host_instruction = 8'hA1;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("arith_fetch2_busy", {63'd0, busy_flag}, 64'd1);
    host_instruction = 8'h03;
    @(negedge clk);
    instr_valid = 1'b0;
    host_instruction = 8'h00;
    chk("arith_exec_selects",
        {49'd0, chunk_read_from_bram, line_read_from_host, aa_mux_sel, dd_mux_sel, arithmetic_mux_sel, bram_in_mux_sel},
        {49'd0, 4'b0000, 4'b0000, 2'd0, 2'd1, 2'd2, 1'b0});
    wait_idle(n);
    chk("arith_exec_write_cycles", 64'(n), 64'd2);

    // COPY 8'hC6: aa=1, dest=2; dd and arith keep their previous values.
    q_chunk.push_back({21'd0, 4'b0100, 2'd1, 2'd1, 2'd2, 1'b1});
    issue(8'hC6);
    wait_idle(n);
    chk("copy_busy_cycles", 64'(n), 64'd2);
    @(negedge clk);
    chk("idle_hold",
        {42'd0, aa_mux_sel, bram_in_mux_sel, dd_mux_sel, arithmetic_mux_sel, offset, chunk_read_from_bram, data_out_valid},
        {42'd0, 2'd1, 1'b1, 2'd1, 2'd2, 9'd63, 4'b0000, 1'b0});

    // LOAD 8'h00 interrupted by reset after 30 bytes.
    issue(8'h00);
    for (int i = 0; i < 30; i++) begin
      data_valid = 1'b1;
      data_in = 8'(8'h80 + i);
      q_load.push_back({11'd0, 4'b0001, 9'(i), 8'(8'h80 + i)});
      @(negedge clk);
    end
    data_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", all_outputs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // STORE 8'h42 after reset starts at offset 0.
    for (int i = 0; i < 64; i++) q_store.push_back({21'd0, 2'd2, 9'(i)});
    store_run(8'h42, 0, 8'h00, n);
    chk("store42_busy_cycles", 64'(n), 64'd65);

    // STORE 8'h43 with 8'hFF while offset 10 is presented.
`ifdef MAU_CTRL_ABORT_EN
    abort_valids = 10;
    abort_busy = 11;
`else
    abort_valids = 64;
    abort_busy = 65;
`endif
    for (int i = 0; i < abort_valids; i++) q_store.push_back({21'd0, 2'd3, 9'(i)});
    store_run(8'h43, 11, 8'hFF, n);
    chk("store43_busy_cycles", 64'(n), 64'(abort_busy));

    repeat (3) @(negedge clk);
    chk("idle_after_all", {63'd0, busy_flag}, 64'd0);
    chk("q_load_empty", 64'(q_load.size()), 64'd0);
    chk("q_store_empty", 64'(q_store.size()), 64'd0);
    chk("q_chunk_empty", 64'(q_chunk.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
